hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
Decode-stage hazard controller and scoreboard. It is the producer-side counterpart of the EX/MEM operand forwarding path. It decides when an instruction in ID may not issue, because its operands cannot be forwarded in time. It also tracks the destination of the single in-flight multi-cycle divide and raises that divide's write-back on the dedicated second register-file write port. Outputs drive the PC, IF/ID and ID/EX pipeline-register enables and flushes.

Parameters:
REG_NUM_BITWIDTH, 5, register index width (32 architectural registers)
DIV_LATENCY, 8, cycles from divide issue (ID->EX edge) to its write-back cycle; legal range 2..255

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous, active-high reset
id_valid  in  1  ID holds a real instruction
id_Rs1  in  REG_NUM_BITWIDTH  ID source 1 index
id_Rs2  in  REG_NUM_BITWIDTH  ID source 2 index
id_useRs1  in  1  instruction reads Rs1
id_useRs2  in  1  instruction reads Rs2
id_Rd  in  REG_NUM_BITWIDTH  ID destination index
id_regWrite  in  1  instruction writes Rd
id_isDiv  in  1  instruction is DIV/DIVU/REM/REMU
ex_Rd  in  REG_NUM_BITWIDTH  EX destination index
ex_memRead  in  1  EX instruction is a load
ex_branchTaken  in  1  EX resolved a taken branch or jump (redirect)
pc_stall  out  1  hold PC
ifid_stall  out  1  hold IF/ID
ifid_flush  out  1  clear IF/ID to bubble
idex_flush  out  1  insert bubble into ID/EX
div_issue  out  1  divide leaves ID this cycle; divider starts
div_busy  out  1  divider occupied
div_wbValid  out  1  divide result written this cycle (port 2 write enable)
div_wbRd  out  REG_NUM_BITWIDTH  port 2 destination
scoreboard  out  32  pending-write bit per register, bit 0 is always 0

Behaviour:
- Reset (async, immediate): scoreboard=0, divider counter=0, div_rd_q=0. All outputs are 0 while rst=1 and in the first cycle after release.
- Source match rule: rsN_hit = id_useRsN && id_RsN!=0. x0 never causes a hazard and is never scoreboarded.
- Load-use hazard: ex_memRead && ex_Rd!=0 && (ex_Rd matches a hit Rs1 or a hit Rs2). Costs exactly 1 stall cycle.
- Scoreboard RAW hazard: any hit source has scoreboard[RsN]=1, except when div_wbValid=1 and div_wbRd==RsN. In that case there is no stall, because the register file is write-first.
- Scoreboard WAW hazard: id_regWrite && id_Rd!=0 && scoreboard[id_Rd]=1 && !(div_wbValid && div_wbRd==id_Rd).
- Structural hazard: id_isDiv && div_busy.
- stall = id_valid && (loadUse || RAW || WAW || structural).
- Stall outputs: pc_stall=ifid_stall=idex_flush=stall.
- Redirect: ex_branchTaken=1 forces ifid_flush=1 and idex_flush=1, and forces pc_stall=ifid_stall=0. Redirect overrides stall, so the stalled instruction is discarded.
- div_issue = id_valid && id_isDiv && !stall && !ex_branchTaken. This is combinational.
- Divider counter (8-bit):
  - On div_issue, load DIV_LATENCY. Otherwise decrement while nonzero.
  - div_busy = (counter > 1).
  - div_wbValid = (counter == 1).
  - div_wbRd = div_rd_q, which is latched on div_issue.
  - A new divide may therefore issue in the write-back cycle of the previous divide (back-to-back issue).
- Divide timing: a divide issued in cycle T writes back in cycle T+DIV_LATENCY. For DIV_LATENCY=8 that is 8 cycles after issue.
- Scoreboard update at each edge:
  - Clear bit div_wbRd if div_wbValid.
  - Then set bit id_Rd if div_issue && id_Rd!=0.
  - Set wins over clear when the indices are equal.
- In-flight divides are unaffected by redirect. Only a divide still in ID is cancelled (no issue, no scoreboard set).
- Reset asserted mid-divide: the counter and scoreboard clear immediately. No div_wbValid is produced for the aborted divide.

Test Plan:
1. Load-use: ex_memRead=1, ex_Rd=5; ID reads Rs1=5 -> stall for exactly 1 cycle (pc_stall=ifid_stall=idex_flush=1). The next cycle, with ex_memRead=0, stall=0.
2. x0 immunity: ex_memRead=1, ex_Rd=0, id_Rs1=0 -> no stall. Divide to Rd=0 -> scoreboard stays 0, and div_wbValid still pulses at T+8.
3. Divide RAW: DIV to x7 issued at T. Dependent ADD reading x7 arrives at T+1 -> stalls T+1..T+7 and proceeds at T+8, when div_wbValid=1 and div_wbRd=7. scoreboard[7] is 0 from T+9.
4. Back-to-back divides: DIV x3 at T, then DIV x4 waits (div_busy) until T+8 and issues then. Its div_wbValid occurs at T+16 with div_wbRd=4. DIV x3 then DIV x3 on the same register: scoreboard[3] stays 1 across the T+8 edge.
5. Redirect over stall: load-use stall active and ex_branchTaken=1 in the same cycle -> ifid_flush=idex_flush=1, pc_stall=0. A DIV sitting in ID in that cycle -> div_issue=0 and scoreboard unchanged.
6. Reset mid-divide: assert rst at T+4 of a divide to x9 -> scoreboard=0 and div_busy=0 immediately, and no div_wbValid occurs after reset is released.

Source files
------------

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
//
// Decode-stage hazard controller and scoreboard. It decides when the
// instruction sitting in ID has to wait because its operands cannot be
// forwarded in time. It also owns the single multi-cycle divider slot: it
// counts the divide's latency, remembers its destination, and raises the
// write-back on the second register-file write port.
//
// Ports:
//   clk, rst           pipeline clock (rising edge), async active-high reset
//   id_*               decoded fields of the instruction in ID
//   ex_Rd, ex_memRead  destination of the EX instruction, and whether it is a load
//   ex_branchTaken     EX redirect (taken branch or jump)
//   pc_stall           hold PC
//   ifid_stall         hold IF/ID
//   ifid_flush         clear IF/ID
//   idex_flush         insert a bubble into ID/EX
//   div_issue          divide leaves ID this cycle
//   div_busy           divider occupied (a new divide must wait)
//   div_wbValid        write-port-2 enable for the divide result
//   div_wbRd           write-port-2 destination
//   scoreboard         pending-write bit per register (bit 0 always 0)

module hazard_stall_unit #(
    parameter int REG_NUM_BITWIDTH = 5,
    parameter int DIV_LATENCY      = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        id_valid,
    input  logic [REG_NUM_BITWIDTH-1:0] id_Rs1,
    input  logic [REG_NUM_BITWIDTH-1:0] id_Rs2,
    input  logic                        id_useRs1,
    input  logic                        id_useRs2,
    input  logic [REG_NUM_BITWIDTH-1:0] id_Rd,
    input  logic                        id_regWrite,
    input  logic                        id_isDiv,
    input  logic [REG_NUM_BITWIDTH-1:0] ex_Rd,
    input  logic                        ex_memRead,
    input  logic                        ex_branchTaken,
    output logic                        pc_stall,
    output logic                        ifid_stall,
    output logic                        ifid_flush,
    output logic                        idex_flush,
    output logic                        div_issue,
    output logic                        div_busy,
    output logic                        div_wbValid,
    output logic [REG_NUM_BITWIDTH-1:0] div_wbRd,
    output logic [31:0]                 scoreboard
);

    localparam logic [7:0] DIV_LOAD = 8'(DIV_LATENCY);

    logic                        active_q;
    logic [7:0]                  div_cnt_q;
    logic [REG_NUM_BITWIDTH-1:0] div_rd_q;
    logic [31:0]                 sb_q;
    logic [31:0]                 sb_d;

    logic rs1_hit;
    logic rs2_hit;
    logic rs1_pending;
    logic rs2_pending;
    logic rd_pending;
    logic load_use;
    logic raw_hazard;
    logic waw_hazard;
    logic struct_hazard;
    logic stall;
    logic redirect;

    // active_q is low while reset is held and during the first cycle after
    // release; the control outputs stay quiet until the pipeline has seen
    // one clean edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= 1'b0;
        end else begin
            active_q <= 1'b1;
        end
    end

    assign div_busy    = (div_cnt_q > 8'd1);
    assign div_wbValid = (div_cnt_q == 8'd1);
    assign div_wbRd    = div_rd_q;
    assign scoreboard  = sb_q;

    assign rs1_hit = id_useRs1 && (id_Rs1 != '0);
    assign rs2_hit = id_useRs2 && (id_Rs2 != '0);

    // A register being written back on port 2 this very cycle is no longer
    // a hazard: the register file is write-first, so ID reads the new value.
    assign rs1_pending = sb_q[id_Rs1] && !(div_wbValid && (div_rd_q == id_Rs1));
    assign rs2_pending = sb_q[id_Rs2] && !(div_wbValid && (div_rd_q == id_Rs2));
    assign rd_pending  = sb_q[id_Rd]  && !(div_wbValid && (div_rd_q == id_Rd));

    assign load_use = ex_memRead && (ex_Rd != '0) &&
                      ((rs1_hit && (ex_Rd == id_Rs1)) || (rs2_hit && (ex_Rd == id_Rs2)));
    assign raw_hazard    = (rs1_hit && rs1_pending) || (rs2_hit && rs2_pending);
    assign waw_hazard    = id_regWrite && (id_Rd != '0) && rd_pending;
    assign struct_hazard = id_isDiv && div_busy;

    assign stall    = active_q && id_valid &&
                      (load_use || raw_hazard || waw_hazard || struct_hazard);
    assign redirect = active_q && ex_branchTaken;

    // Redirect wins over a stall: the stalled instruction is on the wrong
    // path, so IF/ID and ID/EX are both flushed and the PC must move.
    assign pc_stall   = stall && !redirect;
    assign ifid_stall = stall && !redirect;
    assign ifid_flush = redirect;
    assign idex_flush = stall || redirect;

    assign div_issue = active_q && id_valid && id_isDiv && !stall && !ex_branchTaken;

    // The counter reaches 1 exactly DIV_LATENCY cycles after the issue
    // cycle; that is the write-back cycle, and a new divide may issue in it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= 8'd0;
            div_rd_q  <= '0;
        end else begin
            if (div_issue) begin
                div_cnt_q <= DIV_LOAD;
                div_rd_q  <= id_Rd;
            end else if (div_cnt_q != 8'd0) begin
                div_cnt_q <= div_cnt_q - 8'd1;
            end
        end
    end

    // Clear for the retiring divide first, then set for the issuing one, so
    // a back-to-back divide to the same register keeps its bit pending.
    always_comb begin
        sb_d = sb_q;
        if (div_wbValid) begin
            sb_d[div_rd_q] = 1'b0;
        end
        if (div_issue && (id_Rd != '0)) begin
            sb_d[id_Rd] = 1'b1;
        end
        sb_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit
//
// Self-checking bench for hazard_stall_unit. A timestamp-based model of the
// divider slot and a per-register pending set predict every output on each
// falling edge. Directed scenarios add literal expectations, and a long
// randomized run follows.

module tb_hazard_stall_unit;

    localparam int LAT = 8;

    typedef struct packed {
        logic       rst;
        logic       id_valid;
        logic [4:0] id_Rs1;
        logic [4:0] id_Rs2;
        logic       id_useRs1;
        logic       id_useRs2;
        logic [4:0] id_Rd;
        logic       id_regWrite;
        logic       id_isDiv;
        logic [4:0] ex_Rd;
        logic       ex_memRead;
        logic       ex_branchTaken;
    } stim_t;

    typedef struct packed {
        logic        pc_stall;
        logic        ifid_stall;
        logic        ifid_flush;
        logic        idex_flush;
        logic        div_issue;
        logic        div_busy;
        logic        div_wbValid;
        logic [4:0]  div_wbRd;
        logic [31:0] scoreboard;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0;
    logic [4:0]  id_Rs1 = '0;
    logic [4:0]  id_Rs2 = '0;
    logic        id_useRs1 = 1'b0;
    logic        id_useRs2 = 1'b0;
    logic [4:0]  id_Rd = '0;
    logic        id_regWrite = 1'b0;
    logic        id_isDiv = 1'b0;
    logic [4:0]  ex_Rd = '0;
    logic        ex_memRead = 1'b0;
    logic        ex_branchTaken = 1'b0;
    logic        pc_stall;
    logic        ifid_stall;
    logic        ifid_flush;
    logic        idex_flush;
    logic        div_issue;
    logic        div_busy;
    logic        div_wbValid;
    logic [4:0]  div_wbRd;
    logic [31:0] scoreboard;

    int vectors = 0;
    int compares = 0;
    int miscompares = 0;

    // Model state: the divide in flight is described by the cycle number it
    // issued in, and each register simply has a pending flag.
    logic        active = 1'b0;
    logic        inflight = 1'b0;
    int          now = 0;
    int          issueAt = 0;
    logic [4:0]  lastRd = '0;
    logic [31:0] pend = '0;
    exp_t        pred = '0;

    hazard_stall_unit #(
        .REG_NUM_BITWIDTH(5),
        .DIV_LATENCY(LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .id_valid(id_valid),
        .id_Rs1(id_Rs1),
        .id_Rs2(id_Rs2),
        .id_useRs1(id_useRs1),
        .id_useRs2(id_useRs2),
        .id_Rd(id_Rd),
        .id_regWrite(id_regWrite),
        .id_isDiv(id_isDiv),
        .ex_Rd(ex_Rd),
        .ex_memRead(ex_memRead),
        .ex_branchTaken(ex_branchTaken),
        .pc_stall(pc_stall),
        .ifid_stall(ifid_stall),
        .ifid_flush(ifid_flush),
        .idex_flush(idex_flush),
        .div_issue(div_issue),
        .div_busy(div_busy),
        .div_wbValid(div_wbValid),
        .div_wbRd(div_wbRd),
        .scoreboard(scoreboard)
    );

    always #5 clk = ~clk;

    // A register still waits on the divider unless it is being written back
    // in this cycle.
    function automatic logic blocked(input logic [4:0] r, input logic wb);
        return pend[r] && !(wb && (lastRd == r));
    endfunction

    function automatic exp_t modelOut();
        exp_t e;
        logic wb;
        logic loadUse;
        logic waits;
        logic stall;
        e = '0;
        if (!active) return e;
        wb            = inflight && (now == issueAt + LAT);
        e.div_wbValid = wb;
        e.div_busy    = inflight && (now < issueAt + LAT);
        e.div_wbRd    = lastRd;
        e.scoreboard  = pend;
        loadUse = ex_memRead && (ex_Rd != 0) &&
                  ((id_useRs1 && (id_Rs1 == ex_Rd)) || (id_useRs2 && (id_Rs2 == ex_Rd)));
        waits   = (id_useRs1 && (id_Rs1 != 0) && blocked(id_Rs1, wb)) ||
                  (id_useRs2 && (id_Rs2 != 0) && blocked(id_Rs2, wb)) ||
                  (id_regWrite && (id_Rd != 0) && blocked(id_Rd, wb)) ||
                  (id_isDiv && e.div_busy);
        stall   = id_valid && (loadUse || waits);
        if (ex_branchTaken) begin
            e.ifid_flush = 1'b1;
            e.idex_flush = 1'b1;
        end else begin
            e.pc_stall   = stall;
            e.ifid_stall = stall;
            e.idex_flush = stall;
        end
        e.div_issue = id_valid && id_isDiv && !stall && !ex_branchTaken;
        return e;
    endfunction

    // Advance the model on each edge using the prediction made for the
    // cycle that is ending.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            active   <= 1'b0;
            inflight <= 1'b0;
            now      <= 0;
            issueAt  <= 0;
            lastRd   <= '0;
            pend     <= '0;
        end else begin
            if (pred.div_wbValid) pend[lastRd] <= 1'b0;
            if (pred.div_issue) begin
                inflight <= 1'b1;
                issueAt  <= now;
                lastRd   <= id_Rd;
                if (id_Rd != 0) pend[id_Rd] <= 1'b1;
            end
            now    <= now + 1;
            active <= 1'b1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compares++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // One compare per falling edge against the model.
    always @(negedge clk) begin : compare
        exp_t e;
        e = modelOut();
        pred <= e;
        checkOutput("pc_stall",    32'(pc_stall),    32'(e.pc_stall));
        checkOutput("ifid_stall",  32'(ifid_stall),  32'(e.ifid_stall));
        checkOutput("ifid_flush",  32'(ifid_flush),  32'(e.ifid_flush));
        checkOutput("idex_flush",  32'(idex_flush),  32'(e.idex_flush));
        checkOutput("div_issue",   32'(div_issue),   32'(e.div_issue));
        checkOutput("div_busy",    32'(div_busy),    32'(e.div_busy));
        checkOutput("div_wbValid", 32'(div_wbValid), 32'(e.div_wbValid));
        checkOutput("div_wbRd",    32'(div_wbRd),    32'(e.div_wbRd));
        checkOutput("scoreboard",  scoreboard,       e.scoreboard);
    end

    task automatic applyStimulus(input stim_t s);
        @(posedge clk);
        #1;
        rst            = s.rst;
        id_valid       = s.id_valid;
        id_Rs1         = s.id_Rs1;
        id_Rs2         = s.id_Rs2;
        id_useRs1      = s.id_useRs1;
        id_useRs2      = s.id_useRs2;
        id_Rd          = s.id_Rd;
        id_regWrite    = s.id_regWrite;
        id_isDiv       = s.id_isDiv;
        ex_Rd          = s.ex_Rd;
        ex_memRead     = s.ex_memRead;
        ex_branchTaken = s.ex_branchTaken;
        vectors++;
        #2;
    endtask

    function automatic stim_t divTo(input logic [4:0] rd);
        stim_t s;
        s = '0;
        s.id_valid    = 1'b1;
        s.id_isDiv    = 1'b1;
        s.id_regWrite = 1'b1;
        s.id_Rd       = rd;
        return s;
    endfunction

    function automatic stim_t randomStim();
        stim_t s;
        s = '0;
        s.rst            = ($urandom_range(0, 399) == 0);
        s.id_valid       = ($urandom_range(0, 4) != 0);
        s.id_Rs1         = 5'($urandom_range(0, 7));
        s.id_Rs2         = 5'($urandom_range(0, 7));
        s.id_useRs1      = 1'($urandom);
        s.id_useRs2      = 1'($urandom);
        s.id_Rd          = 5'($urandom_range(0, 7));
        s.id_regWrite    = 1'($urandom);
        s.id_isDiv       = ($urandom_range(0, 4) == 0);
        s.ex_Rd          = 5'($urandom_range(0, 7));
        s.ex_memRead     = ($urandom_range(0, 2) == 0);
        s.ex_branchTaken = ($urandom_range(0, 9) == 0);
        return s;
    endfunction

    initial begin
        stim_t s;
        stim_t idle;
        idle = '0;

        $display("[TB] hazard_stall_unit bench starting");

        // Reset, then a hostile first cycle after release: everything stays 0.
        s = idle;
        s.rst = 1'b1;
        applyStimulus(s);
        checkOutput("reset scoreboard", scoreboard, 32'h0);
        applyStimulus(s);
        s = idle;
        s.id_valid = 1'b1; s.id_useRs1 = 1'b1; s.id_Rs1 = 5'd5;
        s.ex_memRead = 1'b1; s.ex_Rd = 5'd5; s.ex_branchTaken = 1'b1;
        applyStimulus(s);
        checkOutput("post-reset pc_stall",   32'(pc_stall),   32'h0);
        checkOutput("post-reset ifid_flush", 32'(ifid_flush), 32'h0);
        checkOutput("post-reset idex_flush", 32'(idex_flush), 32'h0);

        // Load-use: one stall, gone once the load has moved on.
        s = idle;
        s.id_valid = 1'b1; s.id_useRs1 = 1'b1; s.id_Rs1 = 5'd5;
        s.ex_memRead = 1'b1; s.ex_Rd = 5'd5;
        applyStimulus(s);
        checkOutput("load-use pc_stall",   32'(pc_stall),   32'h1);
        checkOutput("load-use ifid_stall", 32'(ifid_stall), 32'h1);
        checkOutput("load-use idex_flush", 32'(idex_flush), 32'h1);
        s.ex_memRead = 1'b0;
        applyStimulus(s);
        checkOutput("load-use released", 32'(pc_stall), 32'h0);

        // x0 never hazards and is never scoreboarded.
        s = idle;
        s.id_valid = 1'b1; s.id_useRs1 = 1'b1; s.id_Rs1 = 5'd0;
        s.ex_memRead = 1'b1; s.ex_Rd = 5'd0;
        applyStimulus(s);
        checkOutput("x0 load-use", 32'(pc_stall), 32'h0);
        applyStimulus(divTo(5'd0));
        checkOutput("div x0 issue", 32'(div_issue), 32'h1);
        for (int k = 1; k <= LAT; k++) begin
            applyStimulus(idle);
            checkOutput("div x0 scoreboard", scoreboard, 32'h0);
            checkOutput("div x0 wbValid", 32'(div_wbValid), (k == LAT) ? 32'h1 : 32'h0);
        end

        // Divide RAW: dependent add stalls until the write-back cycle.
        applyStimulus(divTo(5'd7));
        s = idle;
        s.id_valid = 1'b1; s.id_useRs1 = 1'b1; s.id_Rs1 = 5'd7;
        s.id_regWrite = 1'b1; s.id_Rd = 5'd10;
        for (int k = 1; k <= LAT; k++) begin
            applyStimulus(s);
            checkOutput("div RAW stall", 32'(pc_stall), (k < LAT) ? 32'h1 : 32'h0);
        end
        checkOutput("div RAW wbValid", 32'(div_wbValid), 32'h1);
        checkOutput("div RAW wbRd",    32'(div_wbRd),    32'd7);
        applyStimulus(idle);
        checkOutput("div RAW sb7 cleared", 32'(scoreboard[7]), 32'h0);

        // Back-to-back divides to different registers.
        applyStimulus(divTo(5'd3));
        for (int k = 1; k <= LAT; k++) begin
            applyStimulus(divTo(5'd4));
            checkOutput("div x4 issue", 32'(div_issue), (k == LAT) ? 32'h1 : 32'h0);
        end
        checkOutput("div x3 wbRd", 32'(div_wbRd), 32'd3);
        for (int k = LAT + 1; k <= 2 * LAT; k++) applyStimulus(idle);
        checkOutput("div x4 wbValid", 32'(div_wbValid), 32'h1);
        checkOutput("div x4 wbRd",    32'(div_wbRd),    32'd4);

        // Same destination back to back: set wins over clear.
        applyStimulus(divTo(5'd3));
        for (int k = 1; k <= LAT; k++) applyStimulus(divTo(5'd3));
        checkOutput("div x3 reissue", 32'(div_issue), 32'h1);
        applyStimulus(idle);
        checkOutput("sb3 held", scoreboard, 32'h0000_0008);
        for (int k = LAT + 2; k <= 2 * LAT + 1; k++) applyStimulus(idle);
        checkOutput("sb drained", scoreboard, 32'h0);

        // Redirect over a load-use stall with a divide in ID.
        s = divTo(5'd12);
        s.id_useRs1 = 1'b1; s.id_Rs1 = 5'd5;
        s.ex_memRead = 1'b1; s.ex_Rd = 5'd5; s.ex_branchTaken = 1'b1;
        applyStimulus(s);
        checkOutput("redirect ifid_flush", 32'(ifid_flush), 32'h1);
        checkOutput("redirect idex_flush", 32'(idex_flush), 32'h1);
        checkOutput("redirect pc_stall",   32'(pc_stall),   32'h0);
        checkOutput("redirect div_issue",  32'(div_issue),  32'h0);
        applyStimulus(idle);
        checkOutput("redirect scoreboard", scoreboard, 32'h0);
        checkOutput("redirect div_busy",   32'(div_busy), 32'h0);

        // Reset in the middle of a divide.
        applyStimulus(divTo(5'd9));
        for (int k = 1; k <= 3; k++) applyStimulus(idle);
        checkOutput("mid-div sb9", scoreboard, 32'h0000_0200);
        s = idle;
        s.rst = 1'b1;
        applyStimulus(s);
        checkOutput("mid-div reset sb",   scoreboard,       32'h0);
        checkOutput("mid-div reset busy", 32'(div_busy),    32'h0);
        applyStimulus(s);
        for (int k = 0; k < 12; k++) begin
            applyStimulus(idle);
            checkOutput("aborted div wbValid", 32'(div_wbValid), 32'h0);
        end

        // Randomized run; the falling-edge compare does the checking.
        for (int n = 0; n < 3000; n++) begin
            s = randomStim();
            applyStimulus(s);
        end
        applyStimulus(idle);
        @(negedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
